grouped_update_sequencer: RTL and testbench
===========================================

Name: grouped_update_sequencer

Overview:
- Generates the group index that drives the grouped p-bit update-order decoder.
- Steps the index 0 → 1 → … → NUM_GROUPS-1 and repeats, holding each group for a programmable dwell time.
- Counts complete sweeps, supports fixed-length and free-running annealing runs, and stops only on sweep boundaries so every p-bit gets an equal number of updates.
- Sits directly upstream of the update-order decoder; the decoder consumes group_EN, and update_valid gates the decoded p-bit enables.

Parameters:
- NUM_GROUPS, 3, number of update groups; index range 0..NUM_GROUPS-1.
- IDX_W, 3, width of the group index bus; must hold NUM_GROUPS-1.
- DWELL_W, 8, width of the dwell-cycle configuration.
- SWEEP_W, 16, width of the sweep target and sweep counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a run; ignored while busy.
- stop  input  1  request to end a free-running or fixed run at the next sweep boundary.
- dwell_cycles  input  DWELL_W  extra hold cycles per group; a group is held for dwell_cycles+1 cycles. Sampled on accepted start.
- num_sweeps  input  SWEEP_W  sweeps per run; 0 means free-run until stop. Sampled on accepted start.
- group_EN  output  [0:IDX_W-1]  binary group index to the decoder.
- update_valid  output  1  high while group_EN designates a group being updated.
- sweep_count  output  SWEEP_W  completed sweeps in the current or last run.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse at run end.

Behaviour:
- Reset (asynchronous, reset_n low): state=IDLE, group_EN=0, update_valid=0, sweep_count=0, busy=0, done=0, dwell counter=0, stop_pending=0, latched configuration=0. Reset mid-run aborts immediately; no done pulse.
- IDLE: update_valid=0; group_EN=0. Downstream must gate with update_valid, because index 0 decodes to a live enable.
- Start accepted in IDLE: latch dwell_cycles and num_sweeps, clear sweep_count and stop_pending. Next cycle: state=RUN, group_EN=0, update_valid=1, busy=1.
- A stop asserted in the same cycle as an accepted start is ignored.
- RUN:
  - Dwell counter counts 0..dwell_lat; group_EN is constant throughout.
  - When the counter reaches dwell_lat, it resets to 0 and group_EN advances by 1.
  - At group NUM_GROUPS-1 the index wraps to 0 and sweep_count increments in the same edge. sweep_count saturates at 2^SWEEP_W-1.
  - End condition at the wrap edge: (num_lat≠0 and the new sweep_count==num_lat) or stop_pending=1 or stop=1. When met, go to DONE instead of wrapping: update_valid=0, group_EN=0.
- stop mid-sweep: set stop_pending and move to DRAIN. DRAIN behaves exactly like RUN, except that the end condition is forced true at the next wrap. Outputs are identical to RUN.
- DONE (one cycle): done=1, busy=0, update_valid=0; sweep_count holds its final value. Next state is IDLE.
- start in the DONE cycle is ignored. sweep_count holds until the next accepted start.
- Latency: the first update_valid cycle is 1 cycle after the start edge. Total run length = num_sweeps×NUM_GROUPS×(dwell+1) update_valid cycles.
- Configuration inputs changing during a run have no effect.
- start while busy: ignored; no state change.

Test Plan:
- Reset, then start with dwell=0, num_sweeps=2 -> group_EN sequence 0,1,2,0,1,2 with update_valid high for exactly 6 cycles; done pulses on cycle 7; sweep_count=2; busy low.
- dwell=3, num_sweeps=1 -> each index held 4 cycles (12 valid cycles); sweep_count increments only at the final wrap; done on cycle 13.
- num_sweeps=0, dwell=1, stop asserted while group_EN=1 in sweep 5 -> groups 1 and 2 complete (dwell respected), then done; sweep_count=5; no partial sweep.
- start pulsed during RUN with different dwell and num_sweeps values -> ignored; the original sequence and sweep total are unchanged.
- reset_n dropped mid-dwell at group 2 -> all outputs reach reset values asynchronously, before the next clock edge; no done pulse; a fresh start afterwards begins at group 0 with sweep_count=0.
- start and stop asserted together, num_sweeps=1, dwell=0 -> stop ignored; one full sweep 0,1,2 then done with sweep_count=1.

Source files
------------

// File: rtl/grouped_update_sequencer.sv
// ============================================================================
// grouped_update_sequencer
// Steps the p-bit update group index with a programmable dwell per group,
// counts full sweeps and ends runs only on sweep boundaries.
// Revision: 1.0
// ============================================================================
`default_nettype none

module grouped_update_sequencer #(
  parameter int NUM_GROUPS = 3,
  parameter int IDX_W      = 3,
  parameter int DWELL_W    = 8,
  parameter int SWEEP_W    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic [SWEEP_W-1:0] num_sweeps,
  output logic [0:IDX_W-1]   group_EN,
  output logic               update_valid,
  output logic [SWEEP_W-1:0] sweep_count,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_W-1:0]   C_LAST_GROUP = IDX_W'(NUM_GROUPS - 1);
  localparam logic [SWEEP_W-1:0] C_SWEEP_MAX  = '1;

  logic [1:0]         r_state;
  logic [IDX_W-1:0]   r_group;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic [DWELL_W-1:0] r_dwell_lat;
  logic [SWEEP_W-1:0] r_num_lat;
  logic [SWEEP_W-1:0] r_sweep_cnt;
  logic               r_stop_pending;

  logic               w_active;
  logic               w_dwell_end;
  logic               w_wrap;
  logic               w_end;
  logic [SWEEP_W-1:0] w_sweep_inc;

  assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_dwell_end = (r_dwell_cnt == r_dwell_lat);
  assign w_wrap      = w_dwell_end && (r_group == C_LAST_GROUP);
  assign w_sweep_inc = (r_sweep_cnt == C_SWEEP_MAX) ? r_sweep_cnt : r_sweep_cnt + 1'b1;

  // Run ends at a wrap when the target is reached, or when any stop is seen;
  // DRAIN only exists because a stop arrived, so it always ends at its wrap.
  assign w_end = ((r_num_lat != '0) && (w_sweep_inc == r_num_lat)) ||
                 r_stop_pending || stop || (r_state == S_DRAIN);

  // Valid/busy/done decode straight from state so reset clears them at once.
  assign update_valid = w_active;
  assign busy         = w_active;
  assign done         = (r_state == S_DONE);
  assign group_EN     = r_group;
  assign sweep_count  = r_sweep_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_group        <= '0;
      r_dwell_cnt    <= '0;
      r_dwell_lat    <= '0;
      r_num_lat      <= '0;
      r_sweep_cnt    <= '0;
      r_stop_pending <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_group     <= '0;
          r_dwell_cnt <= '0;
          if (start) begin
            r_dwell_lat    <= dwell_cycles;
            r_num_lat      <= num_sweeps;
            r_sweep_cnt    <= '0;
            r_stop_pending <= 1'b0;
            r_state        <= S_RUN;
          end
        end
        S_RUN, S_DRAIN: begin
          if (w_dwell_end) begin
            r_dwell_cnt <= '0;
            if (w_wrap) begin
              r_sweep_cnt <= w_sweep_inc;
              r_group     <= '0;
              if (w_end) begin
                r_state <= S_DONE;
              end
            end else begin
              r_group <= r_group + 1'b1;
            end
          end else begin
            r_dwell_cnt <= r_dwell_cnt + 1'b1;
          end
          // A mid-sweep stop is remembered and the sweep is finished in DRAIN.
          if ((r_state == S_RUN) && stop && !w_wrap) begin
            r_stop_pending <= 1'b1;
            r_state        <= S_DRAIN;
          end
        end
        S_DONE: begin
          r_group     <= '0;
          r_dwell_cnt <= '0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_grouped_update_sequencer.sv
// ============================================================================
// tb_grouped_update_sequencer
// Directed self-checking bench for grouped_update_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_grouped_update_sequencer;

  localparam int NUM_GROUPS = 3;
  localparam int IDX_W      = 3;
  localparam int DWELL_W    = 8;
  localparam int SWEEP_W    = 16;

  logic               clk;
  logic               reset_n;
  logic               start;
  logic               stop;
  logic [DWELL_W-1:0] dwell_cycles;
  logic [SWEEP_W-1:0] num_sweeps;
  logic [0:IDX_W-1]   group_EN;
  logic               update_valid;
  logic [SWEEP_W-1:0] sweep_count;
  logic               busy;
  logic               done;

  int total;
  int bad;

  grouped_update_sequencer #(
    .NUM_GROUPS (NUM_GROUPS),
    .IDX_W      (IDX_W),
    .DWELL_W    (DWELL_W),
    .SWEEP_W    (SWEEP_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .stop         (stop),
    .dwell_cycles (dwell_cycles),
    .num_sweeps   (num_sweeps),
    .group_EN     (group_EN),
    .update_valid (update_valid),
    .sweep_count  (sweep_count),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int d, input int n, input logic stp);
    start        = 1'b1;
    stop         = stp;
    dwell_cycles = DWELL_W'(d);
    num_sweeps   = SWEEP_W'(n);
    tick();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic check_active(input string tag, input int grp, input int swp);
    chk({tag, "_grp"},   32'(group_EN), 32'(grp));
    chk({tag, "_valid"}, 32'(update_valid), 32'd1);
    chk({tag, "_busy"},  32'(busy), 32'd1);
    chk({tag, "_sweep"}, 32'(sweep_count), 32'(swp));
  endtask

  task automatic check_sweeps(input string tag, input int d, input int nsw, input int swp0);
    for (int s = 0; s < nsw; s++)
      for (int g = 0; g < NUM_GROUPS; g++)
        for (int k = 0; k <= d; k++) begin
          check_active(tag, g, swp0 + s);
          tick();
        end
  endtask

  task automatic check_done(input string tag, input int swp);
    chk({tag, "_done"},      32'(done), 32'd1);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done_val"},  32'(update_valid), 32'd0);
    chk({tag, "_done_grp"},  32'(group_EN), 32'd0);
    chk({tag, "_done_swp"},  32'(sweep_count), 32'(swp));
    tick();
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_val"},  32'(update_valid), 32'd0);
    chk({tag, "_idle_swp"},  32'(sweep_count), 32'(swp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total        = 0;
    bad          = 0;
    reset_n      = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    dwell_cycles = '0;
    num_sweeps   = '0;
    tick();
    tick();
    chk("rst_grp",   32'(group_EN), 32'd0);
    chk("rst_valid", 32'(update_valid), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_sweep", 32'(sweep_count), 32'd0);
    reset_n = 1'b1;
    tick();

    // dwell=0, two sweeps: 0,1,2,0,1,2 then done
    do_start(0, 2, 1'b0);
    check_sweeps("t1", 0, 2, 0);
    check_done("t1", 2);

    // dwell=3, one sweep: each group held 4 cycles
    do_start(3, 1, 1'b0);
    check_sweeps("t2", 3, 1, 0);
    check_done("t2", 1);

    // free-run dwell=1, stop during group 1 of the fifth sweep
    do_start(1, 0, 1'b0);
    check_sweeps("t3", 1, 4, 0);
    check_active("t3_g0a", 0, 4); tick();
    check_active("t3_g0b", 0, 4); tick();
    check_active("t3_g1a", 1, 4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_active("t3_g1b", 1, 4); tick();
    check_active("t3_g2a", 2, 4); tick();
    check_active("t3_g2b", 2, 4); tick();
    check_done("t3", 5);

    // start pulsed mid-run with other configuration is ignored
    do_start(1, 1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check_active("t4", i / 2, 0);
      if (i == 0) begin
        start        = 1'b1;
        dwell_cycles = 8'd5;
        num_sweeps   = 16'd3;
      end
      tick();
      start = 1'b0;
    end
    check_done("t4", 1);

    // asynchronous reset mid-dwell at group 2
    do_start(3, 1, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    check_active("t5_pre", 2, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_grp",   32'(group_EN), 32'd0);
    chk("t5_async_valid", 32'(update_valid), 32'd0);
    chk("t5_async_busy",  32'(busy), 32'd0);
    chk("t5_async_done",  32'(done), 32'd0);
    chk("t5_async_sweep", 32'(sweep_count), 32'd0);
    tick();
    chk("t5_held_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("t5_post_done", 32'(done), 32'd0);
    do_start(0, 1, 1'b0);
    check_sweeps("t5", 0, 1, 0);
    check_done("t5", 1);

    // start and stop together: stop ignored
    do_start(0, 1, 1'b1);
    check_sweeps("t6", 0, 1, 0);
    check_done("t6", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
